// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed-overflow output is enabled with `define SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B), LSB first, one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow port ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             load;
  logic             shift_en;
  logic             last_bit;
  logic             d;
  logic             bout;

  assign cnt_nxt = cnt + CW'(1);

  full_subtractor u_bit (
    .d    (d),
    .bout (bout),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt_nxt == LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result bits enter at the MSB so the first (LSB) bit lands at diff[0] after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      bin        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      a_sr       <= a;
      b_sr       <= b;
      bin        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (shift_en) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      bin  <= bout;
      cnt  <= cnt_nxt;
      diff <= {d, diff[WIDTH-1:1]};
      if (last_bit) borrow_out <= bout;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_sign;
  logic b_sign;

  // Operand signs are captured because the shift registers consume them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      a_sign <= a[WIDTH-1];
      b_sign <= b[WIDTH-1];
      ovf    <= 1'b0;
    end else if (last_bit) begin
      ovf <= (a_sign != b_sign) & (d != a_sign);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: random and directed operands against an arithmetic model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t m;
    int ua = int'(x);
    int ub = int'(y);
    int sa = int'($signed(x));
    int sb = int'($signed(y));
    int r  = sa - sb;
    m.diff   = 8'((ua - ub + 256) % 256);
    m.borrow = (ua < ub);
    m.ovf    = (r > 127) || (r < -128);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("diff", 32'(diff), 32'(e.diff));
        checkOutput("borrow_out", 32'(borrow_out), 32'(e.borrow));
        checkOutput("busy_with_done", 32'(busy), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic waitDone(input int want_n);
    int n = 0;
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_latency", 32'(n), 32'(want_n));
    @(posedge clk); #1;
    checkOutput("done_width", 32'(done), 32'(0));
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    int busy_cycles = 1;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(model(x, y));
    a = 8'($urandom); b = 8'($urandom);
    checkOutput("busy_after_start", 32'(busy), 32'(1));
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cycles++;
    end
    checkOutput("done_latency", 32'(n), 32'(8));
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(8));
    @(posedge clk); #1;
    checkOutput("done_width", 32'(done), 32'(0));
  endtask

  task automatic holdStartTest();
    int   n = 0;
    logic found = 1'b0;
    logic prev = 1'b1;
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(8'h05, 8'h03));
    while (!found && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) begin
        a = 8'hAA; b = 8'h11;
      end
      if (busy && !prev) found = 1'b1;
      prev = busy;
    end
    checkOutput("reaccept_edge", 32'(n), 32'(10));
    start = 1'b0;
    exp_q.push_back(model(8'hAA, 8'h11));
    waitDone(8);
  endtask

  task automatic midResetTest();
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(model(8'h33, 8'h11));
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_diff", 32'(diff), 32'(0));
    checkOutput("rst_borrow", 32'(borrow_out), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h10, 8'h01);
  endtask

  // Fatal watchdog in case a bounded wait is somehow bypassed.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] dir_a [6];
    logic [7:0] dir_b [6];
    dir_a = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80, 8'h7F};
    dir_b = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h01, 8'hFF};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_diff", 32'(diff), 32'(0));
    checkOutput("reset_borrow", 32'(borrow_out), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(dir_a[i], dir_b[i]);
    holdStartTest();
    midResetTest();
    for (int i = 0; i < 16; i++) applyStimulus(8'($urandom), 8'($urandom));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing A − B one bit per clock, LSB first, through a single full-subtractor bit cell and a registered borrow. It is the inverse-operation companion to the combinational full adder in the arithmetic library. It trades WIDTH+1 cycles of latency for one bit cell of logic, and its start/busy/done handshake lets a controller or bench drive it directly.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on the accepted start edge
- b  input  WIDTH  subtrahend, captured on the accepted start edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  A − B mod 2^WIDTH, held until the next accepted start
- borrow_out  output  1  final borrow (1 ⇔ A < B unsigned), held with diff

Clock/reset: one clock; reset asynchronous, active-low.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge → load a/b shift registers, clear borrow, clear bit counter, clear diff/borrow_out, → SHIFT.
- SHIFT: each edge consumes the LSBs of both registers:
  - d = a0 ^ b0 ^ bin
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
  - d shifts into the diff MSB (right shift); bout is stored as the next bin; counter increments.
  - After the WIDTH-th bit → DONE.
- DONE: borrow_out = final borrow; done=1 for this one cycle only; → IDLE unconditionally.
- start in SHIFT or DONE is ignored; no queuing. Operand changes after acceptance have no effect.
- Counter is ceil(log2(WIDTH+1)) bits. No wrap is possible because the exit compare is at WIDTH.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow_out=0, state=IDLE, internal borrow and counter 0.
- Start accepted at edge k: busy=1 from edge k through edge k+WIDTH, i.e. for WIDTH cycles.
- At edge k+WIDTH: state → DONE. done=1 and diff/borrow_out are final from edge k+WIDTH until edge k+WIDTH+1.
- Earliest next acceptance is edge k+WIDTH+2, giving a throughput of one result per WIDTH+2 cycles.
- diff is an intermediate value while busy=1; consumers sample only on done.
- rst_n low at any time, including mid-SHIFT: all state and outputs take reset values immediately, with no done pulse. Operation resumes at IDLE on the first edge after deassertion.
- busy and done are never high together.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Adds output port ovf (1 bit) giving two's-complement signed overflow: ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured operands.
  - Registered and valid with done; held like diff; reset 0; cleared on an accepted start.
- SERIAL_SUB_OVF_EN undefined: no ovf port, no sign-capture flops. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - default WIDTH constant
- Sub-module full_subtractor: purely combinational bit cell with ports (d, bout, a, b, bin) in output-first order, matching the full adder cell. It is instantiated once and is unit-testable exhaustively (8 rows).
- The top level contains only the FSM, the shift registers, the borrow flop and the counter.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → busy=0, done=0, diff=0x00, borrow_out=0 (ovf=0 when enabled).
- Basic, WIDTH=8: a=0x05, b=0x03, start at edge k → busy for 8 cycles; done at edge k+8 with diff=0x02, borrow_out=0.
- Borrow: a=0x03, b=0x05 → diff=0xFE, borrow_out=1. Boundary cases:
  - a=0x00, b=0x01 → diff=0xFF, borrow_out=1
  - a=0xFF, b=0xFF → diff=0x00, borrow_out=0
- Handshake:
  - Hold start=1 continuously and change a/b mid-SHIFT → result reflects only the first captured operands.
  - Next acceptance occurs exactly at edge k+10.
  - done width is exactly 1 cycle.
- Reset mid-operation: pull rst_n low after 4 SHIFT cycles → outputs zero immediately, no done pulse. A new start of 0x10 − 0x01 then yields diff=0x0F.
- SERIAL_SUB_OVF_EN:
  - 0x80 − 0x01 → diff=0x7F, ovf=1
  - 0x7F − 0xFF → diff=0x80, ovf=1
  - 0x05 − 0x03 → ovf=0
  - without the macro, the port is absent and compilation succeeds.
